// File: rtl/rna_pkg.sv
// Shared constants and types for the treinamento_dabson network and its I/O stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rna_pkg;

  localparam int DATA_W = 19;
  localparam int OUT_W  = 28;

  // Request code from the network asking for the next input sample
  localparam logic [3:0] REQ_NEXT     = 4'd1;
  // Output-stage enable code meaning "result valid"
  localparam logic [3:0] OUT_EN_VALID = 4'd1;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Presentation register state: IDLE has nothing on sample_out, VALID holds an unconsumed sample
  typedef enum logic {
    FEED_IDLE  = 1'b0,
    FEED_VALID = 1'b1
  } feed_state_t;

endpackage

// File: rtl/rna_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; head word is read combinationally.
// Latency: a push is visible at pop_data after one edge.
// Backpressure: a push while full is dropped unless a pop happens on the same edge; pop while empty is ignored.
module rna_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO can still take a word when the head leaves on the same edge
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks net push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rna_sample_feeder.sv
// Pedestal-subtracts ADC codes into signed samples, queues them, presents one at a time to the network.
// Latency: push into empty/idle shows on sample_out after 2 edges; a request with queued data reloads in 1 edge.
// Backpressure: none upstream (pushes into a full queue are dropped and flagged); network paces via req_in.
module rna_sample_feeder #(
  parameter int ADC_W  = 12,
  parameter int DATA_W = 19,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  adc_in,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  pedestal,
  input  logic [3:0]        req_in,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_full,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_flags
);

  import rna_pkg::*;

  feed_state_t             state;
  logic signed [ADC_W:0]   diff;
  logic [DATA_W-1:0]       push_data;
  logic [DATA_W-1:0]       head;
  logic                    fifo_empty;
  logic                    req_next;
  logic                    load;
  logic                    drop;

  // Both operands are zero-extended by one bit, so the difference always fits and never saturates
  assign diff      = $signed({1'b0, adc_in}) - $signed({1'b0, pedestal});
  assign push_data = {{(DATA_W - ADC_W - 1){diff[ADC_W]}}, diff};

  assign req_next  = (req_in == REQ_NEXT);
  // Presentation register pulls the FIFO head whenever it is empty or being consumed
  assign load      = !fifo_empty && ((state == FEED_IDLE) || req_next);
  // Same acceptance rule the FIFO applies internally; mirrored here only to raise the flag
  assign drop      = adc_valid && fifo_full && !load;

  assign sample_valid = (state == FEED_VALID);

  rna_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (adc_valid),
    .push_data (push_data),
    .pop       (load),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Presentation FSM: load head when idle or consumed; fall to idle (holding the old value) when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FEED_IDLE;
      sample_out <= '0;
    end else begin
      case (state)
        FEED_IDLE: begin
          if (!fifo_empty) begin
            sample_out <= head;
            state      <= FEED_VALID;
          end
        end
        FEED_VALID: begin
          if (req_next) begin
            if (!fifo_empty) begin
              sample_out <= head;
            end else begin
              state <= FEED_IDLE;
            end
          end
        end
        default: state <= FEED_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event on the clearing edge takes priority over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      if ((state == FEED_IDLE) && req_next) begin
        underflow <= 1'b1;
      end else if (clr_flags) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rna_sample_feeder.sv
// Self-checking bench for rna_sample_feeder with a queue-based scoreboard.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: exercises overflow, underflow and simultaneous push/pop at full.
module tb_rna_sample_feeder;

  localparam int ADC_W  = 12;
  localparam int DATA_W = 19;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADC_W-1:0]  adc_in = '0;
  logic              adc_valid = 1'b0;
  logic [ADC_W-1:0]  pedestal = '0;
  logic [3:0]        req_in = '0;
  logic              clr_flags = 1'b0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              overflow;
  logic              underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: queued samples (excluding the presented one), presentation register, flags
  logic [DATA_W-1:0] m_q [$];
  logic              m_valid = 1'b0;
  logic [DATA_W-1:0] m_out = '0;
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;

  rna_sample_feeder #(
    .ADC_W  (ADC_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_in       (adc_in),
    .adc_valid    (adc_valid),
    .pedestal     (pedestal),
    .req_in       (req_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_flags    (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] conv(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] p);
    int d;
    d = int'(a) - int'(p);
    return d[DATA_W-1:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_out   = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge
  task automatic cycle(input logic v, input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] p,
                       input logic [3:0] r, input logic c);
    logic              load;
    logic              go_idle;
    logic              accept;
    logic              unf_set;
    logic [DATA_W-1:0] pres;
    adc_valid = v;
    adc_in    = a;
    pedestal  = p;
    req_in    = r;
    clr_flags = c;
    load    = (m_q.size() > 0) && (!m_valid || r == 4'd1);
    go_idle = m_valid && (r == 4'd1) && (m_q.size() == 0);
    accept  = v && ((m_q.size() < DEPTH) || load);
    unf_set = !m_valid && (r == 4'd1);
    pres    = '0;
    if (load) pres = m_q.pop_front();
    if (accept) m_q.push_back(conv(a, p));
    if (v && !accept) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (unf_set) m_unf = 1'b1;
    else if (c) m_unf = 1'b0;
    if (load) begin
      m_valid = 1'b1;
      m_out   = pres;
    end else if (go_idle) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (load) chk("data", 32'(sample_out), 32'(pres));
    chk("valid", 32'(sample_valid), 32'(m_valid));
    chk("out",   32'(sample_out),   32'(m_out));
    chk("count", 32'(fifo_count),   32'(m_q.size()));
    chk("full",  32'(fifo_full),    32'(m_q.size() == DEPTH));
    chk("ovf",   32'(overflow),     32'(m_ovf));
    chk("unf",   32'(underflow),    32'(m_unf));
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_out"},   32'(sample_out),   32'd0);
    chk({pfx, "_valid"}, 32'(sample_valid), 32'd0);
    chk({pfx, "_count"}, 32'(fifo_count),   32'd0);
    chk({pfx, "_full"},  32'(fifo_full),    32'd0);
    chk({pfx, "_ovf"},   32'(overflow),     32'd0);
    chk({pfx, "_unf"},   32'(underflow),    32'd0);
  endtask

  initial begin
    // Power-on reset, checked without any clock edge
    #1 rst = 1'b1;
    #1 check_zero("por");
    #6 rst = 1'b0;
    model_reset();

    // Reset mid-stream: queued samples vanish asynchronously
    for (int i = 0; i < 5; i++) cycle(1'b1, ADC_W'($urandom_range(0, 4095)), '0, 4'd0, 1'b0);
    adc_valid = 1'b0;
    req_in    = 4'd0;
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    #1 rst = 1'b0;
    model_reset();

    // Pedestal subtraction: 350-100, 100-100, 0-100
    cycle(1'b1, 12'd350, 12'd100, 4'd0, 1'b0);
    cycle(1'b1, 12'd100, 12'd100, 4'd0, 1'b0);
    cycle(1'b1, 12'd0,   12'd100, 4'd0, 1'b0);
    chk("ped_first", 32'(sample_out), 32'd250);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 12'd100, (i % 2 == 0) ? 4'd2 : 4'd0, 1'b0);
    chk("hold_out", 32'(sample_out), 32'd250);
    chk("hold_cnt", 32'(fifo_count), 32'd2);
    cycle(1'b0, '0, 12'd100, 4'd1, 1'b0);
    chk("ped_zero", 32'(sample_out), 32'd0);
    cycle(1'b0, '0, 12'd100, 4'd1, 1'b0);
    chk("ped_neg", 32'(sample_out), 32'h7FF9C);
    chk("ped_vld", 32'(sample_valid), 32'd1);
    cycle(1'b0, '0, 12'd100, 4'd1, 1'b0);
    chk("drain_idle", 32'(sample_valid), 32'd0);
    chk("drain_unf0", 32'(underflow), 32'd0);
    cycle(1'b0, '0, 12'd100, 4'd1, 1'b0);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_hold", 32'(sample_out), 32'h7FF9C);
    cycle(1'b0, '0, 12'd100, 4'd0, 1'b1);
    chk("unf_clr", 32'(underflow), 32'd0);

    // Push and request on the same edge while VALID with an empty FIFO: no bypass
    cycle(1'b1, 12'd5, 12'd0, 4'd0, 1'b0);
    cycle(1'b0, 12'd0, 12'd0, 4'd0, 1'b0);
    cycle(1'b1, 12'd7, 12'd0, 4'd1, 1'b0);
    chk("nobyp_vld", 32'(sample_valid), 32'd0);
    chk("nobyp_cnt", 32'(fifo_count), 32'd1);
    cycle(1'b0, 12'd0, 12'd0, 4'd0, 1'b0);
    chk("nobyp_out", 32'(sample_out), 32'd7);
    cycle(1'b0, 12'd0, 12'd0, 4'd1, 1'b0);

    // Fill: 18 pushes with no requests, last one dropped
    for (int i = 0; i < 18; i++) cycle(1'b1, ADC_W'(1000 + i), 12'd0, 4'd0, 1'b0);
    chk("fill_out",  32'(sample_out), 32'd1000);
    chk("fill_cnt",  32'(fifo_count), 32'd16);
    chk("fill_full", 32'(fifo_full),  32'd1);
    chk("fill_ovf",  32'(overflow),   32'd1);
    cycle(1'b0, 12'd0, 12'd0, 4'd0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and request
    cycle(1'b1, 12'd2000, 12'd0, 4'd1, 1'b0);
    chk("fullpp_cnt", 32'(fifo_count), 32'd16);
    chk("fullpp_ovf", 32'(overflow),   32'd0);
    chk("fullpp_out", 32'(sample_out), 32'd1001);

    // Drain everything, then one request too many
    for (int i = 0; i < 16; i++) cycle(1'b0, 12'd0, 12'd0, 4'd1, 1'b0);
    chk("drain_last", 32'(sample_out), 32'd2000);
    cycle(1'b0, 12'd0, 12'd0, 4'd1, 1'b0);
    cycle(1'b0, 12'd0, 12'd0, 4'd1, 1'b0);
    chk("extra_vld", 32'(sample_valid), 32'd0);
    chk("extra_out", 32'(sample_out),   32'd2000);
    chk("extra_unf", 32'(underflow),    32'd1);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [3:0] r;
      logic       c;
      v = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 40) ? 4'd1 : 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 99) < 5);
      cycle(v, ADC_W'($urandom_range(0, 4095)), ADC_W'($urandom_range(0, 4095)), r, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rna_sample_feeder.md
Name: rna_sample_feeder

Overview:
Upstream input stage for treinamento_dabson. It takes the raw ADC sample stream, subtracts the pedestal and sign-extends each sample to the network's 19-bit signed input. Samples are buffered in a FIFO. The head sample is presented on sample_out and advances only when the network raises its next-sample request (req_in == 4'd1). This decouples the ADC rate from the network's variable consumption rate.

Parameters:
ADC_W, 12, unsigned ADC code width
DATA_W, 19, signed sample width delivered to the network
DEPTH, 16, FIFO depth in samples (power of two, >= 2)
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
adc_in  input  ADC_W  raw unsigned ADC code
adc_valid  input  1  adc_in is valid this cycle (push request)
pedestal  input  ADC_W  unsigned baseline; quasi-static, sampled with each push
req_in  input  4  network request code; only 4'd1 means "next sample"
sample_out  output  DATA_W  signed sample presented to the network input
sample_valid  output  1  sample_out holds an unconsumed sample
fifo_count  output  CNT_W  samples stored in the FIFO, excluding the presented sample
fifo_full  output  1  fifo_count == DEPTH
overflow  output  1  sticky: a push was dropped
underflow  output  1  sticky: a request arrived while sample_valid = 0
clr_flags  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async, rst = 1): FIFO empty, fifo_count = 0, sample_out = 0, sample_valid = 0, fifo_full = 0, overflow = 0, underflow = 0. Any contents in flight are discarded.
- Conversion at push:
  - data = zero_ext(adc_in) - zero_ext(pedestal), computed in ADC_W+1 bits signed, then sign-extended to DATA_W.
  - No saturation is needed. Range is [-(2^ADC_W - 1), 2^ADC_W - 1].
- Push: occurs on a rising edge with adc_valid = 1. It is accepted if fifo_count < DEPTH, or if a FIFO pop occurs on the same edge.
  - Otherwise the sample is dropped and overflow is set.
  - A pop happens on the same edge whenever the presentation register loads from the FIFO.
- Presentation register FSM, two states:
  - IDLE (sample_valid = 0), on fifo_count > 0: load the FIFO head into sample_out, pop, go to VALID.
  - VALID, on req_in == 4'd1 with fifo_count > 0: load the next head, pop, stay in VALID.
  - VALID, on req_in == 4'd1 with fifo_count == 0: go to IDLE. sample_out holds its last value.
  - VALID, on any other req_in: hold.
  - IDLE, on req_in == 4'd1: set underflow, stay in IDLE (unless loading per the IDLE rule above).
- req_in values 4'd0 and 4'd2..4'd15 are ignored in every state.
- Latency:
  - Push at edge N into an empty FIFO with IDLE: sample_valid = 1 and sample_out updated after edge N+1 (2-edge latency).
  - A request at edge M with a non-empty FIFO: the new sample is on sample_out after edge M, so the network sees it the next cycle.
- A push and a request on the same edge with fifo_count == 0 and VALID: the push enters the FIFO and the FSM goes IDLE. It reloads at the next edge; no bypass.
- fifo_count: +1 on an accepted push, -1 on a pop, unchanged when both happen. Read/write pointers wrap modulo DEPTH.
- clr_flags = 1 clears both sticky flags on that edge. If a new event occurs on the same edge, set wins.
- Pedestal changes affect only subsequent pushes.

Decomposition:
- Shared package rna_pkg:
  - DATA_W = 19, OUT_W = 28
  - REQ_NEXT = 4'd1, OUT_EN_VALID = 4'd1
  - typedef sample_t as a signed [DATA_W-1:0]
  - The network and its output stage use the same package.
- Sub-module rna_sync_fifo: parameterised by width and depth. It provides push/pop, count, full and empty, with async active-high reset. The FSM, conversion and flags stay in the top module.

Test Plan:
- Reset mid-stream: push 5 samples, pulse rst asynchronously between edges -> all outputs 0 immediately; fifo_count = 0 with no clock edge.
- pedestal = 100; push adc_in = 350, 100, 0 -> sample_out = +250 after 2 edges, then 0 and -100 on successive req_in = 4'd1; sample_valid = 1 throughout.
- req_in = 4'd2 and 4'd0 held for 10 cycles with 3 queued -> sample_out unchanged, fifo_count = 2.
- With DEPTH = 16, push 18 samples with no requests -> presented = 1st sample, fifo_count = 16, fifo_full = 1, 18th dropped, overflow = 1. Then clr_flags -> overflow = 0.
- Drain all samples with req_in = 4'd1, then 1 more request -> sample_valid = 0, sample_out holds the last value, underflow = 1.
- Full FIFO with a simultaneous push and req_in = 4'd1 -> push accepted, fifo_count stays 16, overflow stays 0, order preserved.
